// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the in-order WB stage has priority, and long-latency
// results are buffered in a small FIFO with squash-on-overwrite and a starvation hold request.
module wb_port_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4,
   parameter int DATA_W     = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p_valid,
   input  logic [4:0]        p_reg,
   input  logic [DATA_W-1:0] p_data,
   input  logic              l_valid,
   input  logic [4:0]        l_reg,
   input  logic [DATA_W-1:0] l_data,
   output logic              l_ready,
   output logic              RegWrite,
   output logic [4:0]        WriteRegister,
   output logic [DATA_W-1:0] WriteData,
   output logic [31:0]       pending,
   output logic              hold_pipe
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [AW:0]   OCC_FULL   = (AW + 1)'(DEPTH);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

   logic [4:0]        ent_reg  [DEPTH];
   logic [DATA_W-1:0] ent_data [DEPTH];
   logic [DEPTH-1:0]  ent_vld;
   logic [AW-1:0]     rd_ptr, wr_ptr;
   logic [AW:0]       occ;
   logic [SW-1:0]     starve;

   logic              p_win, head_present, head_valid, fifo_ready;
   logic              bypass, pop, push, l_acc;
   logic              sel_we;
   logic [4:0]        sel_reg;
   logic [DATA_W-1:0] sel_data;
   logic [31:0]       pend_mask;

   assign p_win        = p_valid & (p_reg != 5'd31);
   assign head_present = (occ != '0);
   assign head_valid   = head_present & ent_vld[rd_ptr];
   assign fifo_ready   = (occ != OCC_FULL);
   assign l_acc        = l_valid & fifo_ready;

   // A squashed head still consumes the slot, so bypass waits until the FIFO is truly empty.
   assign bypass = ~p_win & ~head_present & l_valid & (l_reg != 5'd31);
   assign pop    = ~p_win & head_present;
   assign push   = l_acc & (l_reg != 5'd31) & ~bypass & ~(p_win & (l_reg == p_reg));

   always_comb begin
      sel_we   = 1'b0;
      sel_reg  = '0;
      sel_data = '0;
      if (p_win) begin
         sel_we   = 1'b1;
         sel_reg  = p_reg;
         sel_data = p_data;
      end else if (head_valid) begin
         sel_we   = 1'b1;
         sel_reg  = ent_reg[rd_ptr];
         sel_data = ent_data[rd_ptr];
      end else if (bypass) begin
         sel_we   = 1'b1;
         sel_reg  = l_reg;
         sel_data = l_data;
      end
   end

   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i]) pend_mask[ent_reg[i]] = 1'b1;
      end
   end

   assign RegWrite      = reset & sel_we;
   assign WriteRegister = reset ? sel_reg : '0;
   assign WriteData     = reset ? sel_data : '0;
   assign l_ready       = reset & fifo_ready;
   assign pending       = reset ? pend_mask : '0;
   assign hold_pipe     = reset & (starve == STARVE_TOP);

   // FIFO control, entry valid bits and starvation counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ent_vld <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         occ     <= '0;
         starve  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (p_win && (ent_reg[i] == p_reg)) ent_vld[i] <= 1'b0;
         end
         if (pop) begin
            ent_vld[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + AW'(1);
         end
         if (push) begin
            ent_vld[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + AW'(1);
         end
         occ <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         if (!head_present || pop)
            starve <= '0;
         else if (head_valid && p_win && (starve != STARVE_TOP))
            starve <= starve + SW'(1);
      end
   end

   // FIFO payload storage
   always_ff @(posedge clk) begin
      if (push) begin
         ent_reg[wr_ptr]  <= l_reg;
         ent_data[wr_ptr] <= l_data;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus a randomized run against a
// queue-based model of the write-port rules.
module tb_wb_port_arbiter;

   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        p_valid = 1'b0;
   logic [4:0]  p_reg = '0;
   logic [63:0] p_data = '0;
   logic        l_valid = 1'b0;
   logic [4:0]  l_reg = '0;
   logic [63:0] l_data = '0;
   logic        l_ready;
   logic        RegWrite;
   logic [4:0]  WriteRegister;
   logic [63:0] WriteData;
   logic [31:0] pending;
   logic        hold_pipe;

   always #5 clk = ~clk;

   wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .DATA_W(64)) dut (
      .clk(clk), .reset(reset),
      .p_valid(p_valid), .p_reg(p_reg), .p_data(p_data),
      .l_valid(l_valid), .l_reg(l_reg), .l_data(l_data),
      .l_ready(l_ready), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
      .WriteData(WriteData), .pending(pending), .hold_pipe(hold_pipe)
   );

   typedef struct {
      logic [4:0]  r;
      logic [63:0] d;
      bit          v;
   } ent_t;

   ent_t q[$];
   int   starve;
   int   n_checks = 0;
   int   n_pass   = 0;

   logic        exp_we;
   logic [4:0]  exp_wa;
   logic [63:0] exp_wd;
   logic        exp_lr;
   logic [31:0] exp_pend;
   logic        exp_hold;

   // Expected outputs for the current inputs and buffered results.
   function automatic void model_eval();
      bit pw = p_valid && (p_reg != 5'd31);
      exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
      if (pw) begin
         exp_we = 1'b1; exp_wa = p_reg; exp_wd = p_data;
      end else if (q.size() > 0) begin
         if (q[0].v) begin
            exp_we = 1'b1; exp_wa = q[0].r; exp_wd = q[0].d;
         end
      end else if (l_valid && (l_reg != 5'd31)) begin
         exp_we = 1'b1; exp_wa = l_reg; exp_wd = l_data;
      end
      exp_lr = (q.size() < DEPTH);
      exp_pend = '0;
      foreach (q[i]) if (q[i].v) exp_pend[q[i].r] = 1'b1;
      exp_hold = (starve == STARVE_MAX);
   endfunction

   // Advance the model across one clock edge.
   function automatic void model_commit();
      bit pw    = p_valid && (p_reg != 5'd31);
      bit empty = (q.size() == 0);
      bit pop   = !pw && !empty;
      bit byp   = !pw && empty && l_valid && (l_reg != 5'd31);
      bit acc   = l_valid && (q.size() < DEPTH);
      if (empty || pop) starve = 0;
      else if (pw && q[0].v && starve < STARVE_MAX) starve++;
      if (pw) foreach (q[i]) if (q[i].r == p_reg) q[i].v = 1'b0;
      if (pop) void'(q.pop_front());
      if (acc && (l_reg != 5'd31) && !byp && !(pw && (l_reg == p_reg)))
         q.push_back('{r: l_reg, d: l_data, v: 1'b1});
   endfunction

   task automatic drive(input logic pv, input logic [4:0] pr, input logic [63:0] pd,
                        input logic lv, input logic [4:0] lr, input logic [63:0] ld);
      @(negedge clk);
      p_valid = pv; p_reg = pr; p_data = pd;
      l_valid = lv; l_reg = lr; l_data = ld;
      #1;
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      model_commit();
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         p_valid = 1'($urandom); p_reg = 5'($urandom); p_data = {$urandom, $urandom};
         l_valid = 1'($urandom); l_reg = 5'($urandom); l_data = {$urandom, $urandom};
         #1;
         n_checks++;
         if ({RegWrite, l_ready, pending, hold_pipe, WriteRegister, WriteData} !== '0)
            $display("FAIL reset_outputs cyc=%0d got we=%0b lr=%0b pend=%h hold=%0b reg=%0d data=%h, want all zero",
                     c, RegWrite, l_ready, pending, hold_pipe, WriteRegister, WriteData);
         else n_pass++;
      end
      q.delete(); starve = 0;
      drive(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #1;
      n_checks++;
      if (l_ready !== 1'b1) $display("FAIL reset_release_lready got %0b want 1", l_ready);
      else n_pass++;
      tick();
   endtask

   task automatic test_bypass();
      drive(0, 0, 0, 1, 5'd5, 64'hAA);
      n_checks++;
      if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd5, 64'hAA})
         $display("FAIL bypass_write got we=%0b reg=%0d data=%h want 1/5/aa", RegWrite, WriteRegister, WriteData);
      else n_pass++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({RegWrite, pending} !== {1'b0, 32'h0})
         $display("FAIL bypass_after got we=%0b pend=%h want 0/0", RegWrite, pending);
      else n_pass++;
      tick();
   endtask

   task automatic test_priority();
      drive(1, 5'd3, 64'h11, 1, 5'd7, 64'h22);
      n_checks++;
      if ({RegWrite, WriteRegister, WriteData, l_ready} !== {1'b1, 5'd3, 64'h11, 1'b1})
         $display("FAIL prio_p_wins got we=%0b reg=%0d data=%h lr=%0b want 1/3/11/1",
                  RegWrite, WriteRegister, WriteData, l_ready);
      else n_pass++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (pending !== 32'h80) $display("FAIL prio_pending got %h want 00000080", pending);
      else n_pass++;
      n_checks++;
      if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd7, 64'h22})
         $display("FAIL prio_drain got we=%0b reg=%0d data=%h want 1/7/22", RegWrite, WriteRegister, WriteData);
      else n_pass++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({RegWrite, pending} !== {1'b0, 32'h0})
         $display("FAIL prio_cleared got we=%0b pend=%h want 0/0", RegWrite, pending);
      else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      drive(1, 5'd1, 64'h1001, 1, 5'd8, 64'h88);
      tick();
      drive(1, 5'd1, 64'h1002, 1, 5'd9, 64'h99);
      n_checks++;
      if (l_ready !== 1'b1) $display("FAIL full_second_accept got lr=%0b want 1", l_ready);
      else n_pass++;
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1, 5'd1, 64'h2000 + 64'(i), 1, 5'd10, 64'hAB);
         n_checks++;
         if ({l_ready, hold_pipe, pending, RegWrite, WriteRegister} !==
             {1'b0, (i >= 3) ? 1'b1 : 1'b0, 32'h300, 1'b1, 5'd1})
            $display("FAIL full_starve i=%0d got lr=%0b hold=%0b pend=%h we=%0b reg=%0d want lr=0 hold=%0b pend=300 reg=1",
                     i, l_ready, hold_pipe, pending, RegWrite, WriteRegister, (i >= 3));
         else n_pass++;
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({RegWrite, WriteRegister, WriteData, hold_pipe} !== {1'b1, 5'd8, 64'h88, 1'b1})
         $display("FAIL full_drain_x8 got we=%0b reg=%0d data=%h hold=%0b want 1/8/88/1",
                  RegWrite, WriteRegister, WriteData, hold_pipe);
      else n_pass++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({RegWrite, WriteRegister, WriteData, hold_pipe, l_ready} !== {1'b1, 5'd9, 64'h99, 1'b0, 1'b1})
         $display("FAIL full_drain_x9 got we=%0b reg=%0d data=%h hold=%0b lr=%0b want 1/9/99/0/1",
                  RegWrite, WriteRegister, WriteData, hold_pipe, l_ready);
      else n_pass++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({RegWrite, pending} !== {1'b0, 32'h0})
         $display("FAIL full_empty got we=%0b pend=%h want 0/0", RegWrite, pending);
      else n_pass++;
      tick();
   endtask

   task automatic test_squash();
      drive(1, 5'd2, 64'h12, 1, 5'd4, 64'h55);
      tick();
      drive(1, 5'd4, 64'h66, 0, 0, 0);
      n_checks++;
      if ({RegWrite, WriteRegister, WriteData, pending} !== {1'b1, 5'd4, 64'h66, 32'h10})
         $display("FAIL squash_p_write got we=%0b reg=%0d data=%h pend=%h want 1/4/66/10",
                  RegWrite, WriteRegister, WriteData, pending);
      else n_pass++;
      tick();
      drive(0, 0, 0, 1, 5'd6, 64'h77);
      n_checks++;
      if ({RegWrite, pending, l_ready} !== {1'b0, 32'h0, 1'b1})
         $display("FAIL squash_dead_pop got we=%0b reg=%0d data=%h pend=%h lr=%0b want we=0 pend=0 lr=1",
                  RegWrite, WriteRegister, WriteData, pending, l_ready);
      else n_pass++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({RegWrite, WriteRegister, WriteData, pending} !== {1'b1, 5'd6, 64'h77, 32'h40})
         $display("FAIL squash_next_head got we=%0b reg=%0d data=%h pend=%h want 1/6/77/40",
                  RegWrite, WriteRegister, WriteData, pending);
      else n_pass++;
      tick();
      drive(1, 5'd5, 64'h50, 1, 5'd5, 64'h51);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({RegWrite, pending} !== {1'b0, 32'h0})
         $display("FAIL squash_same_cycle got we=%0b reg=%0d data=%h pend=%h want we=0 pend=0",
                  RegWrite, WriteRegister, WriteData, pending);
      else n_pass++;
      tick();
   endtask

   task automatic test_x31();
      drive(0, 0, 0, 1, 5'd31, 64'h31);
      n_checks++;
      if ({RegWrite, l_ready} !== {1'b0, 1'b1})
         $display("FAIL x31_l_accept got we=%0b lr=%0b want 0/1", RegWrite, l_ready);
      else n_pass++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({RegWrite, pending} !== {1'b0, 32'h0})
         $display("FAIL x31_l_discard got we=%0b pend=%h want 0/0", RegWrite, pending);
      else n_pass++;
      tick();
      drive(1, 5'd2, 64'h22, 1, 5'd12, 64'hC0);
      tick();
      drive(1, 5'd31, 64'hDEAD, 0, 0, 0);
      n_checks++;
      if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd12, 64'hC0})
         $display("FAIL x31_p_head got we=%0b reg=%0d data=%h want 1/12/c0", RegWrite, WriteRegister, WriteData);
      else n_pass++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({RegWrite, pending} !== {1'b0, 32'h0})
         $display("FAIL x31_empty got we=%0b pend=%h want 0/0", RegWrite, pending);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      drive(1, 5'd1, 64'h1, 1, 5'd20, 64'h20);
      tick();
      drive(1, 5'd1, 64'h2, 1, 5'd21, 64'h21);
      tick();
      @(negedge clk);
      p_valid = 0; l_valid = 0;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({pending, l_ready, RegWrite, hold_pipe} !== '0)
         $display("FAIL midreset_assert got pend=%h lr=%0b we=%0b hold=%0b want all zero",
                  pending, l_ready, RegWrite, hold_pipe);
      else n_pass++;
      q.delete(); starve = 0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++;
      if ({pending, l_ready, RegWrite} !== {32'h0, 1'b1, 1'b0})
         $display("FAIL midreset_release got pend=%h lr=%0b we=%0b want 0/1/0", pending, l_ready, RegWrite);
      else n_pass++;
      tick();
   endtask

   function automatic logic [4:0] rnd_reg();
      int r = $urandom_range(0, 8);
      return (r == 8) ? 5'd31 : 5'(r);
   endfunction

   task automatic test_random();
      logic hold_prev = 1'b0;
      for (int c = 0; c < 600; c++) begin
         drive(hold_prev ? 1'b0 : 1'($urandom_range(0, 1)), rnd_reg(), {$urandom, $urandom},
               1'($urandom_range(0, 2) != 0), rnd_reg(), {$urandom, $urandom});
         n_checks++;
         if ({RegWrite, WriteRegister, WriteData} !== {exp_we, exp_wa, exp_wd})
            $display("FAIL rand_write cyc=%0d got we=%0b reg=%0d data=%h want we=%0b reg=%0d data=%h",
                     c, RegWrite, WriteRegister, WriteData, exp_we, exp_wa, exp_wd);
         else n_pass++;
         n_checks++;
         if (l_ready !== exp_lr) $display("FAIL rand_lready cyc=%0d got %0b want %0b", c, l_ready, exp_lr);
         else n_pass++;
         n_checks++;
         if (pending !== exp_pend) $display("FAIL rand_pending cyc=%0d got %h want %h", c, pending, exp_pend);
         else n_pass++;
         n_checks++;
         if (hold_pipe !== exp_hold) $display("FAIL rand_hold cyc=%0d got %0b want %0b", c, hold_pipe, exp_hold);
         else n_pass++;
         hold_prev = exp_hold;
         tick();
      end
   endtask

   initial begin
      q.delete();
      starve = 0;
      test_reset();
      test_bypass();
      test_priority();
      test_back_to_back();
      test_squash();
      test_x31();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
